// File: rtl/msk_tx_pkg.sv
// rtl/msk_tx_pkg.sv - shared types and constants for the MSK phase modulator
package msk_tx_pkg;

   // Phase sample: full circle is 64 LSB, so one quarter turn is 16 LSB.
   typedef logic signed [5:0] phase_t;

   localparam phase_t PHASE_QUARTER = 6'sd16;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_t;

   // Per-sample phase increment that spreads a quarter turn evenly across one bit.
   function automatic phase_t phase_step(input int samples_per_bit);
      return phase_t'(int'(PHASE_QUARTER) / samples_per_bit);
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - free-running sample strobe, one cycle high every CLK_PER_SAMPLE cycles
module sample_tick_gen #(
   parameter int CLK_PER_SAMPLE = 1
) (
   input  logic clk,
   input  logic resetn,
   output logic tick_o
);

   localparam int CNT_W = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_SAMPLE - 1);

   if (CLK_PER_SAMPLE < 1) begin : g_bad_cps
      $error("sample_tick_gen: CLK_PER_SAMPLE must be >= 1");
   end

   logic [CNT_W-1:0] cnt;

   // Divider counter; with CLK_PER_SAMPLE=1 it stays at zero so the tick is permanently high.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick_o = (cnt == '0);

endmodule

// File: rtl/msk_phase_modulator.sv
// rtl/msk_phase_modulator.sv - serial bit stream to continuous MSK phase samples (option: MSK_TX_IDLE_SAMPLES_EN)
module msk_phase_modulator
   import msk_tx_pkg::*;
#(
   parameter int SAMPLES_PER_BIT = 4,
   parameter int CLK_PER_SAMPLE  = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       data_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   output logic [5:0] phase_o,
   output logic       ph_valid_o
);

   localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(SAMPLES_PER_BIT - 1);
   localparam phase_t STEP = phase_step(SAMPLES_PER_BIT);

   if (!(SAMPLES_PER_BIT == 1 || SAMPLES_PER_BIT == 2 || SAMPLES_PER_BIT == 4 ||
         SAMPLES_PER_BIT == 8 || SAMPLES_PER_BIT == 16)) begin : g_bad_spb
      $error("msk_phase_modulator: SAMPLES_PER_BIT must be 1, 2, 4, 8 or 16");
   end

   tx_state_t        state;
   logic [CNT_W-1:0] samp_cnt;
   logic             cur_bit;
   phase_t           phase_q;
   logic             ph_valid_q;
   logic             tick;
   logic             last_samp;
   phase_t           delta;

   sample_tick_gen #(
      .CLK_PER_SAMPLE(CLK_PER_SAMPLE)
   ) u_tick (
      .clk    (clk),
      .resetn (resetn),
      .tick_o (tick)
   );

   assign last_samp = (samp_cnt == LAST_SAMP);
   assign delta     = cur_bit ? STEP : -STEP;

   // Ready in IDLE, or on the tick that emits the last sample of the current bit (gapless reload).
   assign data_ready_o = (state == IDLE) || (tick && last_samp);

   // Bit FSM and phase accumulator; phase wraps modulo 64 and is only cleared by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         samp_cnt   <= '0;
         cur_bit    <= 1'b0;
         phase_q    <= '0;
         ph_valid_q <= 1'b0;
      end else begin
         ph_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (data_valid_i) begin
                  cur_bit  <= data_i;
                  samp_cnt <= '0;
                  state    <= SEND;
               end
`ifdef MSK_TX_IDLE_SAMPLES_EN
               else if (tick) begin
                  ph_valid_q <= 1'b1;
               end
`endif
            end
            SEND: begin
               if (tick) begin
                  phase_q    <= phase_q + delta;
                  ph_valid_q <= 1'b1;
                  if (last_samp) begin
                     samp_cnt <= '0;
                     if (data_valid_i) begin
                        cur_bit <= data_i;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     samp_cnt <= samp_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign phase_o    = phase_q;
   assign ph_valid_o = ph_valid_q;

endmodule

// File: tb/tb_msk_phase_modulator.sv
// tb/tb_msk_phase_modulator.sv - directed self-checking bench for msk_phase_modulator
module tb_msk_phase_modulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              a_resetn, a_data, a_valid, a_ready, a_pv;
   logic signed [5:0] a_phase;
   logic              b_resetn, b_data, b_valid, b_ready, b_pv;
   logic signed [5:0] b_phase;

   msk_phase_modulator #(.SAMPLES_PER_BIT(4), .CLK_PER_SAMPLE(1)) dut_a (
      .clk          (clk),
      .resetn       (a_resetn),
      .data_i       (a_data),
      .data_valid_i (a_valid),
      .data_ready_o (a_ready),
      .phase_o      (a_phase),
      .ph_valid_o   (a_pv)
   );

   msk_phase_modulator #(.SAMPLES_PER_BIT(4), .CLK_PER_SAMPLE(3)) dut_b (
      .clk          (clk),
      .resetn       (b_resetn),
      .data_i       (b_data),
      .data_valid_i (b_valid),
      .data_ready_o (b_ready),
      .phase_o      (b_phase),
      .ph_valid_o   (b_pv)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   int  vals[$];
   int  cycs[$];
   int  exp2[12] = '{4, 8, 12, 16, 20, 24, 28, -32, 28, 24, 20, 16};
   int  exp4[4]  = '{-4, -8, -12, -16};
   int  exp5[4]  = '{-12, -8, -4, 0};
   logic bits2[3] = '{1'b1, 1'b1, 1'b0};
   int  idx, xcnt, nstr, exp_idle;
   logic xfer;

   initial begin
      a_resetn = 1'b0; a_valid = 1'b0; a_data = 1'b0;
      b_resetn = 1'b0; b_valid = 1'b0; b_data = 1'b0;
      repeat (3) @(posedge clk);
      #1 a_resetn = 1'b1; b_resetn = 1'b1;

      // Test 1: reset mid-bit with phase 12
      @(posedge clk); #1 a_valid = 1'b1; a_data = 1'b1;
      @(posedge clk); #1 a_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t1_phase_mid", a_phase, 12);
      check("t1_pv_mid", a_pv, 1);
      #2 a_resetn = 1'b0;
      #1;
      check("t1_phase_async_rst", a_phase, 0);
      check("t1_pv_async_rst", a_pv, 0);
      @(posedge clk); #1 a_resetn = 1'b1;
      @(negedge clk);
      check("t1_ready_after_rst", a_ready, 1);
      check("t1_phase_after_rst", a_phase, 0);

      // Tests 2/3: bits 1,1,0 streamed gapless, wrap through -32
      @(posedge clk); #1;
      idx = 0; xcnt = 0;
      a_valid = 1'b1; a_data = bits2[0];
      vals.delete(); cycs.delete();
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         xfer = a_valid && a_ready;
         @(posedge clk); #1;
         if (a_pv) begin
            vals.push_back(int'(a_phase));
            cycs.push_back(c);
         end
         if ($isunknown({a_phase, a_pv, a_ready})) xcnt++;
         if (xfer) begin
            idx++;
            if (idx < 3) a_data = bits2[idx];
            else a_valid = 1'b0;
         end
      end
      check("t2_strobe_count", vals.size(), 12);
      for (int i = 0; i < 12; i++) begin
         if (i < vals.size()) check($sformatf("t2_phase_%0d", i), vals[i], exp2[i]);
         else check($sformatf("t2_phase_%0d_missing", i), 0, 1);
      end
      if (cycs.size() == 12) check("t2_no_gap", cycs[11] - cycs[0], 11);
      else check("t2_no_gap_count", cycs.size(), 12);
      check("t3_no_x", xcnt, 0);

      // Test 4: CPS=3, single bit 0, then valid low
      @(posedge clk); #1 b_valid = 1'b1; b_data = 1'b0;
      @(posedge clk); #1 b_valid = 1'b0;
      vals.delete(); cycs.delete();
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (b_pv) begin
            vals.push_back(int'(b_phase));
            cycs.push_back(c);
         end
      end
      check("t4_strobe_count", vals.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < vals.size()) check($sformatf("t4_phase_%0d", i), vals[i], exp4[i]);
         else check($sformatf("t4_phase_%0d_missing", i), 0, 1);
      end
      for (int i = 1; i < 4; i++) begin
         if (i < cycs.size()) check($sformatf("t4_spacing_%0d", i), cycs[i] - cycs[i-1], 3);
      end
      @(negedge clk);
      check("t4_ready_idle", b_ready, 1);
      check("t4_phase_hold", b_phase, -16);

      // Test 6: 5 ticks of IDLE
`ifdef MSK_TX_IDLE_SAMPLES_EN
      exp_idle = 5;
`else
      exp_idle = 0;
`endif
      nstr = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (b_pv) nstr++;
      end
      check("t6_idle_strobes", nstr, exp_idle);
      check("t6_idle_phase", b_phase, -16);

      // Test 5: valid pulses during SEND while ready=0 are not accepted
      @(posedge clk); #1 b_valid = 1'b1; b_data = 1'b1;
      @(posedge clk); #1;
      vals.delete(); cycs.delete();
      for (int k = 0; k < 12; k++) begin
         b_valid = (k < 2);
         b_data  = 1'b0;
         if (k < 2) begin
            @(negedge clk);
            check($sformatf("t5_ready_busy_%0d", k), b_ready, 0);
         end
         @(posedge clk); #1;
         if (b_pv) vals.push_back(int'(b_phase));
      end
      b_valid = 1'b0;
      check("t5_strobe_count", vals.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < vals.size()) check($sformatf("t5_phase_%0d", i), vals[i], exp5[i]);
         else check($sformatf("t5_phase_%0d_missing", i), 0, 1);
      end
      @(negedge clk);
      check("t5_ready_idle", b_ready, 1);
      check("t5_phase_final", b_phase, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
